// File: rtl/vp_gfx_pixel.sv
// Graphics pixel serialiser: turns attribute cells (fg/bg/bitmap/enable) into a
// stream of 4-bit colour indices, one per pixel clock enable, with a one-cell hold buffer.
module vp_gfx_pixel #(
    parameter int WIDTH = 16,
    parameter int CELLS = 80
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_ce,
    input  logic             line_start,
    input  logic             gfx_valid,
    output logic             gfx_ready,
    input  logic [3:0]       gfx_foreground,
    input  logic [3:0]       gfx_background,
    input  logic [WIDTH-1:0] gfx_bitmap,
    input  logic             enable,
    output logic [3:0]       pixel_color,
    output logic             pixel_gfx,
    output logic             pixel_valid,
    output logic             underrun,
    output logic             line_done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CELL_LAST = CW'(CELLS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic             hold_full_q, hold_full_d;
    logic [3:0]       hold_fg_q, hold_fg_d;
    logic [3:0]       hold_bg_q, hold_bg_d;
    logic [WIDTH-1:0] hold_bm_q, hold_bm_d;
    logic             hold_en_q, hold_en_d;

    logic [3:0]       cur_fg_q, cur_fg_d;
    logic [3:0]       cur_bg_q, cur_bg_d;
    logic [WIDTH-1:0] cur_bm_q, cur_bm_d;
    logic             cur_en_q, cur_en_d;

    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    cell_cnt_q, cell_cnt_d;

    logic [3:0]       pixel_color_q, pixel_color_d;
    logic             pixel_gfx_q, pixel_gfx_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic             underrun_q, underrun_d;
    logic             line_done_q, line_done_d;

    logic             start_line, emit, cell_start, consume, accept, last_pixel, pix_bit;
    logic [3:0]       src_fg, src_bg;
    logic [WIDTH-1:0] src_bm;
    logic             src_en;

    always_comb begin
        start_line = (state_q == IDLE) && pix_ce && line_start;
        emit       = pix_ce && ((state_q == RUN) || start_line);
        cell_start = emit && (bit_cnt_q == '0);
        consume    = cell_start && hold_full_q;
        gfx_ready  = !hold_full_q || consume;
        accept     = gfx_valid && gfx_ready;
        last_pixel = (cell_cnt_q == CELL_LAST) && (bit_cnt_q == BIT_LAST);

        // The pixel source is the hold buffer at a cell start (blank if it ran dry),
        // otherwise the cell already latched for this span.
        src_fg = cur_fg_q;
        src_bg = cur_bg_q;
        src_bm = cur_bm_q;
        src_en = cur_en_q;
        if (cell_start) begin
            src_fg = hold_full_q ? hold_fg_q : 4'h0;
            src_bg = hold_full_q ? hold_bg_q : 4'h0;
            src_bm = hold_full_q ? hold_bm_q : '0;
            src_en = hold_full_q ? hold_en_q : 1'b0;
        end
        pix_bit = src_bm[BIT_LAST - bit_cnt_q];

        hold_full_d = hold_full_q;
        hold_fg_d   = hold_fg_q;
        hold_bg_d   = hold_bg_q;
        hold_bm_d   = hold_bm_q;
        hold_en_d   = hold_en_q;
        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_fg_d   = gfx_foreground;
            hold_bg_d   = gfx_background;
            hold_bm_d   = gfx_bitmap;
            hold_en_d   = enable;
        end

        cur_fg_d = cur_fg_q;
        cur_bg_d = cur_bg_q;
        cur_bm_d = cur_bm_q;
        cur_en_d = cur_en_q;
        if (cell_start) begin
            cur_fg_d = src_fg;
            cur_bg_d = src_bg;
            cur_bm_d = src_bm;
            cur_en_d = src_en;
        end

        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        cell_cnt_d    = cell_cnt_q;
        pixel_color_d = pixel_color_q;
        pixel_gfx_d   = pixel_gfx_q;
        pixel_valid_d = 1'b0;
        underrun_d    = 1'b0;
        line_done_d   = 1'b0;
        if (emit) begin
            pixel_valid_d = 1'b1;
            underrun_d    = cell_start && !hold_full_q;
            pixel_color_d = src_en ? (pix_bit ? src_fg : src_bg) : 4'h0;
            pixel_gfx_d   = src_en;
            state_d       = RUN;
            if (last_pixel) begin
                state_d     = IDLE;
                bit_cnt_d   = '0;
                cell_cnt_d  = '0;
                line_done_d = 1'b1;
            end else if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d  = '0;
                cell_cnt_d = cell_cnt_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hold_full_q   <= 1'b0;
            hold_fg_q     <= 4'h0;
            hold_bg_q     <= 4'h0;
            hold_bm_q     <= '0;
            hold_en_q     <= 1'b0;
            cur_fg_q      <= 4'h0;
            cur_bg_q      <= 4'h0;
            cur_bm_q      <= '0;
            cur_en_q      <= 1'b0;
            bit_cnt_q     <= '0;
            cell_cnt_q    <= '0;
            pixel_color_q <= 4'h0;
            pixel_gfx_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
            line_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_full_q   <= hold_full_d;
            hold_fg_q     <= hold_fg_d;
            hold_bg_q     <= hold_bg_d;
            hold_bm_q     <= hold_bm_d;
            hold_en_q     <= hold_en_d;
            cur_fg_q      <= cur_fg_d;
            cur_bg_q      <= cur_bg_d;
            cur_bm_q      <= cur_bm_d;
            cur_en_q      <= cur_en_d;
            bit_cnt_q     <= bit_cnt_d;
            cell_cnt_q    <= cell_cnt_d;
            pixel_color_q <= pixel_color_d;
            pixel_gfx_q   <= pixel_gfx_d;
            pixel_valid_q <= pixel_valid_d;
            underrun_q    <= underrun_d;
            line_done_q   <= line_done_d;
        end
    end

    assign pixel_color = pixel_color_q;
    assign pixel_gfx   = pixel_gfx_q;
    assign pixel_valid = pixel_valid_q;
    assign underrun    = underrun_q;
    assign line_done   = line_done_q;

endmodule

// File: tb/tb_vp_gfx_pixel.sv
// Directed bench for vp_gfx_pixel with a two-cell line of 16-pixel cells.
module tb_vp_gfx_pixel;

   localparam int WIDTH = 16;
   localparam int CELLS = 2;
   localparam int NPIX  = WIDTH * CELLS;

   typedef struct packed {
      logic [3:0]  fg;
      logic [3:0]  bg;
      logic [15:0] bm;
      logic        en;
   } cell_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pixCe = 1'b0;
   logic        lineStart = 1'b0;
   logic        gfxValid = 1'b0;
   logic [3:0]  gfxFg = 4'h0;
   logic [3:0]  gfxBg = 4'h0;
   logic [15:0] gfxBm = 16'h0;
   logic        enableIn = 1'b0;
   logic        gfxReady;
   logic [3:0]  pixelColor;
   logic        pixelGfx;
   logic        pixelValid;
   logic        underrun;
   logic        lineDone;

   int          checks;
   int          errors;
   cell_t       sendQ[$];
   logic [3:0]  expColor[NPIX];
   logic        expGfx[NPIX];
   logic        expUr[NPIX];
   bit          acc;

   // Cells used by the scenarios
   localparam cell_t CELL_A  = '{fg: 4'hA, bg: 4'h3, bm: 16'h8001, en: 1'b1};
   localparam cell_t CELL_D  = '{fg: 4'h5, bg: 4'h2, bm: 16'hFFFF, en: 1'b0};
   localparam cell_t CELL_C  = '{fg: 4'h7, bg: 4'h2, bm: 16'hF0F0, en: 1'b1};
   localparam cell_t CELL_S0 = '{fg: 4'h1, bg: 4'hE, bm: 16'hC003, en: 1'b1};
   localparam cell_t CELL_S1 = '{fg: 4'h9, bg: 4'h6, bm: 16'h0FF0, en: 1'b1};
   localparam cell_t CELL_S2 = '{fg: 4'hB, bg: 4'hD, bm: 16'h5555, en: 1'b1};
   localparam cell_t CELL_R  = '{fg: 4'hC, bg: 4'h1, bm: 16'h1234, en: 1'b1};

   vp_gfx_pixel #(.WIDTH(WIDTH), .CELLS(CELLS)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pix_ce         (pixCe),
      .line_start     (lineStart),
      .gfx_valid      (gfxValid),
      .gfx_ready      (gfxReady),
      .gfx_foreground (gfxFg),
      .gfx_background (gfxBg),
      .gfx_bitmap     (gfxBm),
      .enable         (enableIn),
      .pixel_color    (pixelColor),
      .pixel_gfx      (pixelGfx),
      .pixel_valid    (pixelValid),
      .underrun       (underrun),
      .line_done      (lineDone)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected when it differs
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives pixel enable, line start and (optionally) the head of the send queue
   task automatic applyStimulus(input bit ce, input bit ls, input bit feed);
      pixCe     = ce;
      lineStart = ls;
      if (feed && sendQ.size() > 0) begin
         gfxValid = 1'b1;
         {gfxFg, gfxBg, gfxBm, enableIn} = sendQ[0];
      end else begin
         gfxValid = 1'b0;
      end
   endtask

   // Notes the handshake just before the edge, then moves to 1 ns after it
   task automatic doTick(output bit accepted);
      #1;
      accepted = gfxValid && gfxReady;
      @(posedge clk);
      #1;
      if (accepted) void'(sendQ.pop_front());
   endtask

   // Expected pixels for one cell span: blank if the hold buffer was empty at its start
   task automatic setExp(input int cellIdx, input bit present, input cell_t c);
      for (int b = 0; b < WIDTH; b++) begin
         int   idx;
         logic onBit;
         idx   = cellIdx * WIDTH + b;
         onBit = c.bm[WIDTH-1-b];
         if (present && c.en) begin
            expColor[idx] = onBit ? c.fg : c.bg;
            expGfx[idx]   = 1'b1;
         end else begin
            expColor[idx] = 4'h0;
            expGfx[idx]   = 1'b0;
         end
         expUr[idx] = (b == 0) && !present;
      end
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      applyStimulus(0, 0, 0);
      sendQ.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic idleTicks(input int n);
      bit a;
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, 1);
         doTick(a);
      end
   endtask

   // Runs nPix pixel enables, each preceded by period-1 stalled clocks; feeding starts at pixel feedAt
   task automatic runLine(input int period, input int nPix, input int feedAt, input bit checkNoBubble);
      bit a;
      for (int p = 0; p < nPix; p++) begin
         for (int k = 1; k < period; k++) begin
            applyStimulus(0, 0, p >= feedAt);
            doTick(a);
            checkOutput($sformatf("stall_valid_p%0d", p), pixelValid, 0);
            if (p > 0) checkOutput($sformatf("stall_color_hold_p%0d", p), pixelColor, expColor[p-1]);
         end
         applyStimulus(1, p == 0, p >= feedAt);
         doTick(a);
         if (checkNoBubble && (p % WIDTH) == 0)
            checkOutput($sformatf("accept_at_cell_start_p%0d", p), a, 1);
         checkOutput($sformatf("color_p%0d", p), pixelColor, expColor[p]);
         checkOutput($sformatf("gfx_p%0d", p), pixelGfx, expGfx[p]);
         checkOutput($sformatf("valid_p%0d", p), pixelValid, 1);
         checkOutput($sformatf("underrun_p%0d", p), underrun, expUr[p]);
         checkOutput($sformatf("line_done_p%0d", p), lineDone, p == NPIX - 1);
      end
      applyStimulus(0, 0, 0);
   endtask

   // A pix_ce without line_start after a finished line must not produce a pixel
   task automatic checkIdleAfterLine(input string tag);
      bit a;
      applyStimulus(1, 0, 0);
      doTick(a);
      checkOutput({tag, "_idle_valid"}, pixelValid, 0);
      checkOutput({tag, "_idle_line_done"}, lineDone, 0);
      applyStimulus(0, 0, 0);
   endtask

   // Directed scenario sequence
   initial begin
      checks = 0;
      errors = 0;

      doReset();
      checkOutput("reset_color", pixelColor, 0);
      checkOutput("reset_gfx", pixelGfx, 0);
      checkOutput("reset_valid", pixelValid, 0);
      checkOutput("reset_underrun", underrun, 0);
      checkOutput("reset_line_done", lineDone, 0);
      checkOutput("reset_ready", gfxReady, 1);

      $display("[TB] preloaded cell, enabled then disabled cell");
      sendQ.push_back(CELL_A);
      idleTicks(2);
      checkOutput("preload_ready_low", gfxReady, 0);
      sendQ.push_back(CELL_D);
      setExp(0, 1, CELL_A);
      setExp(1, 1, CELL_D);
      runLine(1, NPIX, 5, 0);
      checkOutput("s1_hold_drained_ready", gfxReady, 1);
      checkIdleAfterLine("s1");

      $display("[TB] underrun at line start");
      doReset();
      sendQ.push_back(CELL_C);
      setExp(0, 0, CELL_C);
      setExp(1, 1, CELL_C);
      runLine(1, NPIX, 3, 0);
      checkIdleAfterLine("s3");

      $display("[TB] pixel enable every third clock");
      doReset();
      sendQ.push_back(CELL_A);
      idleTicks(1);
      sendQ.push_back(CELL_D);
      setExp(0, 1, CELL_A);
      setExp(1, 1, CELL_D);
      runLine(3, NPIX, 5, 0);
      checkIdleAfterLine("s4");

      $display("[TB] gfx_valid held high");
      doReset();
      sendQ.push_back(CELL_S0);
      sendQ.push_back(CELL_S1);
      sendQ.push_back(CELL_S2);
      idleTicks(1);
      setExp(0, 1, CELL_S0);
      setExp(1, 1, CELL_S1);
      runLine(1, NPIX, 0, 1);
      checkOutput("s5_queue_drained", sendQ.size(), 0);
      checkOutput("s5_third_cell_held", gfxReady, 0);

      $display("[TB] reset mid-line");
      doReset();
      sendQ.push_back(CELL_A);
      idleTicks(1);
      sendQ.push_back(CELL_D);
      setExp(0, 1, CELL_A);
      setExp(1, 1, CELL_D);
      runLine(1, 7, 3, 0);
      checkOutput("pre_reset_hold_full", gfxReady, 0);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_color", pixelColor, 0);
      checkOutput("midreset_gfx", pixelGfx, 0);
      checkOutput("midreset_valid", pixelValid, 0);
      checkOutput("midreset_ready", gfxReady, 1);
      applyStimulus(1, 1, 0);
      doTick(acc);
      checkOutput("in_reset_no_pixel", pixelValid, 0);
      applyStimulus(0, 0, 0);
      reset_n = 1'b1;
      sendQ.delete();
      sendQ.push_back(CELL_R);
      idleTicks(1);
      setExp(0, 1, CELL_R);
      setExp(1, 0, CELL_R);
      runLine(1, NPIX, NPIX, 0);
      checkIdleAfterLine("s6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
